// File: rtl/clock_pkg.sv
// clock_pkg: shared button-FSM state type and tick constants for the clock sequencer
package clock_pkg;
   typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, REPEAT} btn_state_t;
   localparam int DEF_TICKS_PER_SEC      = 1000;
   localparam int DEF_DEBOUNCE_TICKS     = 20;
   localparam int DEF_REPEAT_DELAY_TICKS = 500;
   localparam int DEF_REPEAT_RATE_TICKS  = 200;
   function automatic int cmax(input int a, input int b);
      return a > b ? a : b;
   endfunction
   localparam int CNT_W = $clog2(cmax(cmax(DEF_TICKS_PER_SEC, DEF_DEBOUNCE_TICKS),
                                      cmax(DEF_REPEAT_DELAY_TICKS, DEF_REPEAT_RATE_TICKS)));
endpackage

// File: rtl/clock_time_ctrl_if.sv
// clock_time_ctrl_if: tick/button/terminal-count inputs and counter enables of the clock sequencer
interface clock_time_ctrl_if;
   logic tick_ms, adv_hr, adv_min, sec_max, min_max;
   logic enb_sec, enb_min, enb_hr, clr_sec, setting;
   modport master (output tick_ms, adv_hr, adv_min, sec_max, min_max,
                   input  enb_sec, enb_min, enb_hr, clr_sec, setting);
   modport slave  (input  tick_ms, adv_hr, adv_min, sec_max, min_max,
                   output enb_sec, enb_min, enb_hr, clr_sec, setting);
endinterface

// File: rtl/clock_time_ctrl_btn_repeat.sv
// btn_repeat: debounce plus delayed auto-repeat for one set button, counting tick_ms only
module btn_repeat
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_TICKS     = DEF_DEBOUNCE_TICKS,
   parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
   parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS
) (
   input  logic clk,
   input  logic rst,
   input  logic i_tick_ms,
   input  logic i_btn,
   output logic o_pulse,
   output logic o_active
);
   btn_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_lim;
   logic             w_hit;
   always_comb
      w_lim = r_state == DEBOUNCE ? CNT_W'(DEBOUNCE_TICKS - 1) :
              r_state == HELD     ? CNT_W'(REPEAT_DELAY_TICKS - 1) :
                                    CNT_W'(REPEAT_RATE_TICKS - 1);
   assign w_hit    = r_state != IDLE && i_btn && i_tick_ms && r_cnt == w_lim;
   assign o_pulse  = w_hit;
   assign o_active = r_state == HELD || r_state == REPEAT;
   // a low button in any state drops straight back to IDLE, including mid-debounce bounces
   always_ff @(posedge clk)
      if (rst || !i_btn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else if (r_state == IDLE) begin
         r_state <= DEBOUNCE;
         r_cnt   <= '0;
      end else if (w_hit) begin
         r_state <= r_state == DEBOUNCE ? HELD : REPEAT;
         r_cnt   <= '0;
      end else if (i_tick_ms)
         r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: seconds prescaler, set-button sequencing and registered counter enables
module clock_time_ctrl
   import clock_pkg::*;
#(
   parameter int TICKS_PER_SEC      = DEF_TICKS_PER_SEC,
   parameter int DEBOUNCE_TICKS     = DEF_DEBOUNCE_TICKS,
   parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
   parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS
) (
   input logic               clk,
   input logic               rst,
   clock_time_ctrl_if.slave  bus
);
   localparam int PW = $clog2(TICKS_PER_SEC);
   logic [PW-1:0] r_presc;
   logic r_enb_sec, r_enb_min, r_enb_hr, r_clr_sec;
   logic w_p_min, w_p_hr, w_act_min, w_act_hr, w_setting, w_sec_tick;
   btn_repeat #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .REPEAT_DELAY_TICKS(REPEAT_DELAY_TICKS),
                .REPEAT_RATE_TICKS(REPEAT_RATE_TICKS)) u_min (
      .clk(clk), .rst(rst), .i_tick_ms(bus.tick_ms), .i_btn(bus.adv_min),
      .o_pulse(w_p_min), .o_active(w_act_min));
   btn_repeat #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .REPEAT_DELAY_TICKS(REPEAT_DELAY_TICKS),
                .REPEAT_RATE_TICKS(REPEAT_RATE_TICKS)) u_hr (
      .clk(clk), .rst(rst), .i_tick_ms(bus.tick_ms), .i_btn(bus.adv_hr),
      .o_pulse(w_p_hr), .o_active(w_act_hr));
   assign w_setting  = w_act_min || w_act_hr;
   assign w_sec_tick = bus.tick_ms && !w_setting && r_presc == PW'(TICKS_PER_SEC - 1);
   // a minute set restarts the second so it counts from the set instant; clear beats increment
   always_ff @(posedge clk)
      if (rst) begin
         r_presc   <= '0;
         r_enb_sec <= 1'b0;
         r_enb_min <= 1'b0;
         r_enb_hr  <= 1'b0;
         r_clr_sec <= 1'b0;
      end else begin
         r_presc   <= (w_p_min || w_sec_tick) ? '0 :
                      (bus.tick_ms && !w_setting) ? r_presc + 1'b1 : r_presc;
         r_enb_sec <= w_sec_tick && !w_p_min;
         r_enb_min <= (w_sec_tick && bus.sec_max) || w_p_min;
         r_enb_hr  <= (w_sec_tick && bus.sec_max && bus.min_max) || w_p_hr;
         r_clr_sec <= w_p_min;
      end
   assign bus.enb_sec = r_enb_sec;
   assign bus.enb_min = r_enb_min;
   assign bus.enb_hr  = r_enb_hr;
   assign bus.clr_sec = r_clr_sec;
   assign bus.setting = w_setting;
endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: vector table, directed corner sequences and random run against a press-length model
module tb_clock_time_ctrl;
   localparam int T = 10, D = 3, R = 5, P = 2;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   clock_time_ctrl_if ifc();
   clock_time_ctrl #(.TICKS_PER_SEC(T), .DEBOUNCE_TICKS(D), .REPEAT_DELAY_TICKS(R),
                     .REPEAT_RATE_TICKS(P)) dut (.clk(clk), .rst(rst), .bus(ifc));

   int total = 0, bad = 0;
   bit m_pr [2];
   int m_n [2];
   int m_pc;
   logic [4:0] m_exp;
   int n_sec, n_min, n_hr, n_clr, all3, set_seen, tick_no;
   longint sec_mask, min_mask;

   typedef struct {
      logic rst, tick, hr, mn, smax, mmax;
      logic [4:0] exp;
   } vec_t;
   vec_t vecs [16];

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] dut_out();
      return {ifc.enb_sec, ifc.enb_min, ifc.enb_hr, ifc.clr_sec, ifc.setting};
   endfunction

   // pulses fall where the k-th ticked, continuously-held tick lands on D, D+R, then every P
   function automatic bit fires(input int k);
      return k == D || k == D + R || (k > D + R && (k - D - R) % P == 0);
   endfunction

   task automatic model_step();
      bit btn [2];
      bit p [2];
      bit set_now, st;
      btn[0] = ifc.adv_min;
      btn[1] = ifc.adv_hr;
      if (rst) begin
         m_pr = '{0, 0};
         m_n = '{0, 0};
         m_pc = 0;
         m_exp = '0;
         return;
      end
      set_now = (m_pr[0] && m_n[0] >= D) || (m_pr[1] && m_n[1] >= D);
      for (int b = 0; b < 2; b++) p[b] = m_pr[b] && btn[b] && ifc.tick_ms && fires(m_n[b] + 1);
      st = ifc.tick_ms && !set_now && m_pc == T - 1;
      if (p[0]) m_pc = 0;
      else if (ifc.tick_ms && !set_now) m_pc = (m_pc + 1) % T;
      for (int b = 0; b < 2; b++)
         if (!btn[b]) begin m_pr[b] = 0; m_n[b] = 0; end
         else if (!m_pr[b]) begin m_pr[b] = 1; m_n[b] = 0; end
         else if (ifc.tick_ms) m_n[b]++;
      m_exp = {st && !p[0], (st && ifc.sec_max) || p[0], (st && ifc.sec_max && ifc.min_max) || p[1],
               p[0], (m_pr[0] && m_n[0] >= D) || (m_pr[1] && m_n[1] >= D)};
   endtask

   task automatic clr_obs();
      n_sec = 0; n_min = 0; n_hr = 0; n_clr = 0; all3 = 0; set_seen = 0; tick_no = 0;
      sec_mask = 0; min_mask = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      if (ifc.tick_ms && !rst) tick_no++;
      check("model", dut_out(), m_exp);
      n_sec += ifc.enb_sec; n_min += ifc.enb_min; n_hr += ifc.enb_hr; n_clr += ifc.clr_sec;
      all3 += ifc.enb_sec & ifc.enb_min & ifc.enb_hr;
      set_seen |= ifc.setting;
      if (tick_no < 63) begin
         if (ifc.enb_sec) sec_mask |= 64'd1 << tick_no;
         if (ifc.enb_min) min_mask |= 64'd1 << tick_no;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         ifc.tick_ms = 1'b1; cyc();
         ifc.tick_ms = 1'b0; cyc(); cyc(); cyc();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; cyc();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ifc.tick_ms = 0; ifc.adv_hr = 0; ifc.adv_min = 0; ifc.sec_max = 0; ifc.min_max = 0;
      clr_obs();
      cyc(); cyc();
      check("reset_state", dut_out(), 5'b0);
      rst = 1'b0;

      vecs[0]  = '{1, 0, 0, 0, 0, 0, 5'b00000};
      vecs[1]  = '{0, 0, 1, 0, 0, 0, 5'b00000};
      vecs[2]  = '{0, 1, 1, 0, 0, 0, 5'b00000};
      vecs[3]  = '{0, 1, 1, 0, 0, 0, 5'b00000};
      vecs[4]  = '{0, 1, 1, 0, 0, 0, 5'b00101};
      vecs[5]  = '{0, 1, 1, 0, 0, 0, 5'b00001};
      vecs[6]  = '{0, 0, 0, 0, 0, 0, 5'b00000};
      vecs[7]  = '{0, 0, 0, 1, 0, 0, 5'b00000};
      vecs[8]  = '{0, 1, 0, 1, 0, 0, 5'b00000};
      vecs[9]  = '{0, 1, 0, 0, 0, 0, 5'b00000};
      for (int i = 10; i < 14; i++) vecs[i] = '{0, 1, 0, 0, 1, 1, 5'b00000};
      vecs[14] = '{0, 1, 0, 0, 1, 1, 5'b11100};
      vecs[15] = '{0, 0, 0, 0, 1, 1, 5'b00000};
      for (int i = 0; i < 16; i++) begin
         rst = vecs[i].rst; ifc.tick_ms = vecs[i].tick; ifc.adv_hr = vecs[i].hr;
         ifc.adv_min = vecs[i].mn; ifc.sec_max = vecs[i].smax; ifc.min_max = vecs[i].mmax;
         cyc();
         check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
      end
      rst = 0; ifc.tick_ms = 0; ifc.sec_max = 0; ifc.min_max = 0;

      do_reset(); clr_obs();
      ticks(25);
      check("free_sec_ticks", sec_mask, (64'd1 << 10) | (64'd1 << 20));
      check("free_min_hr", n_min + n_hr, 0);

      do_reset(); ifc.sec_max = 1; ifc.min_max = 1; clr_obs();
      ticks(10);
      check("cascade_all3", all3, 1);
      check("cascade_sec_cycles", n_sec, 1);

      do_reset(); ifc.sec_max = 0; ifc.min_max = 0; clr_obs();
      ifc.adv_min = 1; cyc(); ticks(2); ifc.adv_min = 0; cyc();
      check("bounce_pulses", n_min + n_clr, 0);
      check("bounce_setting", set_seen, 0);
      clr_obs();
      ifc.adv_min = 1; cyc(); ticks(12);
      check("hold_min_ticks", min_mask, (64'd1 << 3) | (64'd1 << 8) | (64'd1 << 10) | (64'd1 << 12));
      check("hold_clr_count", n_clr, 4);
      check("hold_sec_frozen", n_sec, 0);
      ticks(1);
      ifc.adv_min = 0; cyc();
      check("release_setting", ifc.setting, 0);
      clr_obs();
      ticks(10);
      check("resume_sec_tick", sec_mask, 64'd1 << 10);

      do_reset(); ifc.sec_max = 1; ifc.min_max = 0; clr_obs();
      ticks(7);
      ifc.adv_min = 1; cyc(); ticks(2);
      ifc.tick_ms = 1; cyc();
      check("coincide_outputs", dut_out(), 5'b01011);
      ifc.tick_ms = 0; cyc();
      check("coincide_min_width", ifc.enb_min, 0);
      ifc.adv_min = 0; cyc();

      do_reset(); ifc.sec_max = 0; clr_obs();
      ifc.adv_hr = 1; cyc(); ticks(4);
      check("held_hr_pulse", n_hr, 1);
      rst = 1; cyc();
      check("rst_in_held", dut_out(), 5'b0);
      rst = 0; cyc(); clr_obs();
      ticks(2);
      check("post_rst_no_pulse", n_hr, 0);
      ticks(1);
      check("post_rst_debounced", n_hr, 1);
      ifc.adv_hr = 0; cyc();

      do_reset();
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 599) == 0);
         ifc.tick_ms = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 39) == 0) ifc.adv_min = ~ifc.adv_min;
         if ($urandom_range(0, 39) == 0) ifc.adv_hr = ~ifc.adv_hr;
         if ($urandom_range(0, 7) == 0) ifc.sec_max = $urandom_range(0, 1);
         if ($urandom_range(0, 7) == 0) ifc.min_max = $urandom_range(0, 1);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
Sequencing controller for the digital-clock timekeeping datapath. Consumes the 1 ms enable from period_enb and the two raw set buttons. Drives single-cycle enables and a clear into the sec/min/hr counter_rc_mod instances, including rollover cascade, debounce and auto-repeat. Sits between period_enb and the counters inside dig_clock.

Parameters:
TICKS_PER_SEC, 1000, tick_ms pulses per second
DEBOUNCE_TICKS, 20, consecutive asserted ticks before a press is accepted
REPEAT_DELAY_TICKS, 500, held ticks after acceptance before the first auto-repeat
REPEAT_RATE_TICKS, 200, ticks between subsequent auto-repeats

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick_ms  in  1  one-cycle 1 ms enable from period_enb
adv_hr  in  1  raw hour-set button, level, already synchronized
adv_min  in  1  raw minute-set button, level, already synchronized
sec_max  in  1  seconds counter at terminal value (59), level
min_max  in  1  minutes counter at terminal value (59), level
enb_sec  out  1  one-cycle increment to seconds counter
enb_min  out  1  one-cycle increment to minutes counter
enb_hr  out  1  one-cycle increment to hours counter
clr_sec  out  1  one-cycle clear to seconds counter
setting  out  1  high while either button is in HELD or REPEAT

Behaviour:
- Synchronous active-high reset. After reset all outputs are 0, the prescaler is 0, and both button FSMs are IDLE. Reset mid-press returns to IDLE with no pulse.
- All outputs are registered. An event caused by a tick_ms cycle appears on outputs exactly 1 cycle later.
- Prescaler, 0..TICKS_PER_SEC-1:
  - Increments on tick_ms while setting=0. Holds its value while setting=1.
  - tick_ms at count TICKS_PER_SEC-1 wraps it to 0 and raises sec_tick.
- Button FSM, one instance per button. Counter cnt counts tick_ms only.
  - IDLE: btn=1 -> DEBOUNCE, cnt=0.
  - DEBOUNCE: btn=0 in any cycle -> IDLE. On tick with cnt=DEBOUNCE_TICKS-1 -> HELD, emit pulse, cnt=0. Otherwise on tick, cnt++.
  - HELD: btn=0 -> IDLE immediately. On tick with cnt=REPEAT_DELAY_TICKS-1 -> REPEAT, pulse, cnt=0. Otherwise on tick, cnt++.
  - REPEAT: btn=0 -> IDLE. On tick with cnt=REPEAT_RATE_TICKS-1 -> pulse, cnt=0 (stays in REPEAT). Otherwise on tick, cnt++.
  - Pulses are 1 cycle wide. A bounce shorter than DEBOUNCE_TICKS yields no pulse.
- Output equations, registered. p_min and p_hr are the button pulses.
  - enb_sec = sec_tick & ~p_min.
  - enb_min = (sec_tick & sec_max) | p_min.
  - enb_hr = (sec_tick & sec_max & min_max) | p_hr.
  - clr_sec = p_min.
- p_min also resets the prescaler to 0, so the next second starts from the set instant.
- Set operations never cascade. Advancing minutes from 59 does not touch hours. Hours wrap is owned by the hour counter (0..23).
- Simultaneous events:
  - Both buttons are independent; p_min and p_hr may assert in the same cycle.
  - sec_tick coincident with p_min: clear wins. enb_sec=0 and clr_sec=1. enb_min pulses once (no double increment). The rollover cascade to hours is still honoured if sec_max&min_max.
  - enb_* are never asserted for more than 1 consecutive cycle by the same source.
- setting = (hr FSM in HELD|REPEAT) | (min FSM in HELD|REPEAT), registered with the state.

Decomposition:
- Package clock_pkg holds:
  - typedef enum btn_state_t {IDLE, DEBOUNCE, HELD, REPEAT};
  - localparam defaults for the four tick constants;
  - CNT_W = $clog2 of the largest tick constant.
- Sub-module btn_repeat (clk, rst, tick_ms, btn -> pulse, active) holds one FSM and its cnt. It is instantiated twice.
- Prescaler and output logic live in clock_time_ctrl.

Test Plan (TICKS_PER_SEC=10, DEBOUNCE_TICKS=3, REPEAT_DELAY_TICKS=5, REPEAT_RATE_TICKS=2; tick_ms every 4 cycles):
- Free run 25 ticks, sec_max=0 -> enb_sec pulses 1 cycle after the 10th and 20th ticks only; enb_min/enb_hr stay 0.
- sec_max=1, min_max=1, 10 ticks -> enb_sec, enb_min and enb_hr all high in the same single cycle.
- adv_min high for 2 ticks then low -> no pulse, setting stays 0. Hold adv_min 12 ticks -> enb_min+clr_sec at tick 3, 8, 10, 12; prescaler frozen while setting=1.
- Release adv_min mid-REPEAT -> IDLE next cycle, setting=0, prescaler resumes from 0.
- adv_min pulse aligned with the 10th-tick sec rollover, sec_max=1, min_max=0 -> clr_sec=1, enb_sec=0, enb_min high for exactly 1 cycle.
- Assert rst during HELD on adv_hr -> all outputs 0 next cycle; 2 more held ticks produce no pulse until DEBOUNCE completes again.
